// File: rtl/score_keeper.sv
// score_keeper: match controller for the ball block. It scores the ball's
// edge events, sequences IDLE/SERVE/PLAY/POINT/OVER, holds the ball in reset
// between rallies and feeds it a free-running LFSR for serve randomness.
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 1000,
  parameter int HOLD_TICKS  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_left,
  input  logic       out_right,
  input  logic       start,
  output logic       ball_reset,
  output logic [4:0] entropy,
  output logic [3:0] lscore,
  output logic [3:0] rscore,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over,
  output logic       winner
);

  localparam int MAX_TICKS = (SERVE_TICKS > HOLD_TICKS) ? SERVE_TICKS : HOLD_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_TICKS);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    OVER
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start_q, outl_q, outr_q;
  logic          start_rise, evt_l, evt_r;
  logic [3:0]    lscore_n, rscore_n;
  logic          point_l_n, point_r_n, game_over_n, winner_n;

  assign start_rise = start & ~start_q;
  assign evt_l      = out_left & ~outl_q;
  assign evt_r      = out_right & ~outr_q;

  // Input history so a held button or a held out_* flag fires only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      outl_q  <= 1'b0;
      outr_q  <= 1'b0;
    end else begin
      start_q <= start;
      outl_q  <= out_left;
      outr_q  <= out_right;
    end
  end

  // Free-running x^5+x^3+1 LFSR; seeded non-zero so it never locks up.
  always_ff @(posedge clk) begin
    if (reset) begin
      entropy <= 5'b00001;
    end else begin
      entropy <= {entropy[3:0], entropy[4] ^ entropy[2]};
    end
  end

  // Next-state and next-output decode for the match sequencer.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lscore_n    = lscore;
    rscore_n    = rscore;
    point_l_n   = point_l;
    point_r_n   = point_r;
    game_over_n = game_over;
    winner_n    = winner;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = SERVE;
          cnt_n   = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (cnt == CNT_ONE) begin
          state_n = PLAY;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      PLAY: begin
        if (evt_l && !evt_r) begin
          rscore_n = rscore + 4'd1;
          if (rscore_n == WIN) begin
            state_n     = OVER;
            game_over_n = 1'b1;
            winner_n    = 1'b1;
          end else begin
            state_n   = POINT;
            point_r_n = 1'b1;
            cnt_n     = HOLD_LOAD;
          end
        end else if (evt_r && !evt_l) begin
          lscore_n = lscore + 4'd1;
          if (lscore_n == WIN) begin
            state_n     = OVER;
            game_over_n = 1'b1;
            winner_n    = 1'b0;
          end else begin
            state_n   = POINT;
            point_l_n = 1'b1;
            cnt_n     = HOLD_LOAD;
          end
        end
      end
      POINT: begin
        if (cnt == CNT_ONE) begin
          point_l_n = 1'b0;
          point_r_n = 1'b0;
          state_n   = SERVE;
          cnt_n     = SERVE_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      OVER: begin
        if (start_rise) begin
          lscore_n    = 4'd0;
          rscore_n    = 4'd0;
          game_over_n = 1'b0;
          state_n     = SERVE;
          cnt_n       = SERVE_LOAD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and registered outputs; the ball runs only in PLAY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ball_reset <= 1'b1;
      lscore     <= 4'd0;
      rscore     <= 4'd0;
      point_l    <= 1'b0;
      point_r    <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ball_reset <= (state_n != PLAY);
      lscore     <= lscore_n;
      rscore     <= rscore_n;
      point_l    <= point_l_n;
      point_r    <= point_r_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scenario tasks plus a randomized match checked against a
// simple score/timing model (WIN=3, SERVE=4, HOLD=5).
module tb_score_keeper;

  localparam int WIN = 3;
  localparam int S   = 4;
  localparam int H   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_left = 1'b0;
  logic       out_right = 1'b0;
  logic       start = 1'b0;
  logic       ball_reset;
  logic [4:0] entropy;
  logic [3:0] lscore;
  logic [3:0] rscore;
  logic       point_l;
  logic       point_r;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int fails  = 0;

  score_keeper #(.WIN_SCORE(WIN), .SERVE_TICKS(S), .HOLD_TICKS(H)) dut (
    .clk(clk),
    .reset(reset),
    .out_left(out_left),
    .out_right(out_right),
    .start(start),
    .ball_reset(ball_reset),
    .entropy(entropy),
    .lscore(lscore),
    .rscore(rscore),
    .point_l(point_l),
    .point_r(point_r),
    .game_over(game_over),
    .winner(winner)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Counts samples (including the current one) until ball_reset drops.
  task automatic run_to_play(output int n_br, output int n_pl, output int n_pr);
    n_br = 0;
    n_pl = 0;
    n_pr = 0;
    while (ball_reset === 1'b1 && n_br < 200) begin
      if (point_l === 1'b1) n_pl++;
      if (point_r === 1'b1) n_pr++;
      n_br++;
      step();
    end
  endtask

  task automatic test_reset();
    logic [4:0] ent [0:61];
    bit seen [0:31];
    int zeros, distinct, permis, brlow;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({ball_reset, lscore, rscore, point_l, point_r, game_over, winner} !== {1'b1, 8'd0, 4'd0}) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got br=%0b l=%0d r=%0d pl=%0b pr=%0b go=%0b w=%0b, expected br=1 l=0 r=0 rest 0",
               ball_reset, lscore, rscore, point_l, point_r, game_over, winner);
    end
    checks++;
    if (entropy !== 5'd1) begin
      fails++;
      $display("[TB] FAIL reset_entropy: got %0d, expected 1", entropy);
    end
    reset = 1'b0;
    zeros = 0; brlow = 0; distinct = 0; permis = 0;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 0; i < 62; i++) begin
      step();
      ent[i] = entropy;
      if (entropy == 5'd0) zeros++;
      if (ball_reset !== 1'b1 || lscore !== 4'd0 || rscore !== 4'd0) brlow++;
    end
    for (int i = 0; i < 31; i++) begin
      if (!seen[ent[i]]) begin
        seen[ent[i]] = 1'b1;
        distinct++;
      end
      if (ent[i+31] !== ent[i]) permis++;
    end
    checks++;
    if (zeros != 0) begin
      fails++;
      $display("[TB] FAIL entropy_nonzero: got %0d zero samples, expected 0", zeros);
    end
    checks++;
    if (distinct != 31) begin
      fails++;
      $display("[TB] FAIL entropy_distinct: got %0d distinct values, expected 31", distinct);
    end
    checks++;
    if (permis != 0) begin
      fails++;
      $display("[TB] FAIL entropy_period: got %0d mismatches at lag 31, expected 0", permis);
    end
    checks++;
    if (brlow != 0) begin
      fails++;
      $display("[TB] FAIL idle_hold: got %0d non-idle samples, expected 0", brlow);
    end
  endtask

  task automatic test_start_held();
    int nb, npl, npr;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    run_to_play(nb, npl, npr);
    checks++;
    if (nb != S) begin
      fails++;
      $display("[TB] FAIL start_held_serve: got %0d reset cycles, expected %0d", nb, S);
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_serve();
    int nb, npl, npr;
    checks++;
    if (ball_reset !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_no_start: got br=%0b, expected 1", ball_reset);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_play(nb, npl, npr);
    checks++;
    if (nb != S) begin
      fails++;
      $display("[TB] FAIL serve_length: got %0d, expected %0d", nb, S);
    end
    checks++;
    if (lscore !== 4'd0 || rscore !== 4'd0) begin
      fails++;
      $display("[TB] FAIL serve_scores: got %0d/%0d, expected 0/0", lscore, rscore);
    end
  endtask

  task automatic test_point_held();
    int nb, npl, npr;
    out_right = 1'b1;
    step();
    checks++;
    if (lscore !== 4'd1 || rscore !== 4'd0 || point_l !== 1'b1 || point_r !== 1'b0 || ball_reset !== 1'b1) begin
      fails++;
      $display("[TB] FAIL point_first: got l=%0d r=%0d pl=%0b pr=%0b br=%0b, expected l=1 r=0 pl=1 pr=0 br=1",
               lscore, rscore, point_l, point_r, ball_reset);
    end
    repeat (2) step();
    out_right = 1'b0;
    checks++;
    if (lscore !== 4'd1) begin
      fails++;
      $display("[TB] FAIL point_once: got %0d, expected 1", lscore);
    end
    run_to_play(nb, npl, npr);
    checks++;
    if (nb != H + S - 2) begin
      fails++;
      $display("[TB] FAIL point_recovery: got %0d, expected %0d", nb, H + S - 2);
    end
    checks++;
    if (npl != H - 2 || npr != 0) begin
      fails++;
      $display("[TB] FAIL point_hold: got pl=%0d pr=%0d, expected pl=%0d pr=0", npl, npr, H - 2);
    end
  endtask

  task automatic test_simultaneous();
    out_left = 1'b1;
    out_right = 1'b1;
    step();
    out_left = 1'b0;
    out_right = 1'b0;
    step();
    checks++;
    if (lscore !== 4'd1 || rscore !== 4'd0 || ball_reset !== 1'b0 || point_l !== 1'b0 || point_r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL simultaneous: got l=%0d r=%0d br=%0b pl=%0b pr=%0b, expected l=1 r=0 br=0 pl=0 pr=0",
               lscore, rscore, ball_reset, point_l, point_r);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (ball_reset !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_in_play: got br=%0b, expected 0", ball_reset);
    end
  endtask

  task automatic test_reset_mid_point();
    out_right = 1'b1;
    step();
    out_right = 1'b0;
    checks++;
    if (lscore !== 4'd2 || point_l !== 1'b1) begin
      fails++;
      $display("[TB] FAIL second_point: got l=%0d pl=%0b, expected l=2 pl=1", lscore, point_l);
    end
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if (lscore !== 4'd0 || rscore !== 4'd0 || point_l !== 1'b0 || ball_reset !== 1'b1 || entropy !== 5'd1) begin
      fails++;
      $display("[TB] FAIL reset_mid_point: got l=%0d r=%0d pl=%0b br=%0b ent=%0d, expected l=0 r=0 pl=0 br=1 ent=1",
               lscore, rscore, point_l, ball_reset, entropy);
    end
    reset = 1'b0;
    repeat (10) step();
    checks++;
    if (ball_reset !== 1'b1 || point_l !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got br=%0b pl=%0b, expected br=1 pl=0", ball_reset, point_l);
    end
  endtask

  task automatic test_game_over();
    int nb, npl, npr;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_play(nb, npl, npr);
    for (int k = 1; k <= WIN; k++) begin
      out_left = 1'b1;
      step();
      out_left = 1'b0;
      checks++;
      if (rscore !== 4'(k) || lscore !== 4'd0) begin
        fails++;
        $display("[TB] FAIL go_score: got l=%0d r=%0d, expected l=0 r=%0d", lscore, rscore, k);
      end
      if (k < WIN) begin
        run_to_play(nb, npl, npr);
        checks++;
        if (nb != H + S || npr != H) begin
          fails++;
          $display("[TB] FAIL go_recovery: got br=%0d pr=%0d, expected br=%0d pr=%0d", nb, npr, H + S, H);
        end
      end
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b1 || point_r !== 1'b0 || ball_reset !== 1'b1) begin
      fails++;
      $display("[TB] FAIL go_state: got go=%0b w=%0b pr=%0b br=%0b, expected go=1 w=1 pr=0 br=1",
               game_over, winner, point_r, ball_reset);
    end
    out_right = 1'b1;
    step();
    out_right = 1'b0;
    step();
    checks++;
    if (lscore !== 4'd0 || rscore !== 4'(WIN) || game_over !== 1'b1) begin
      fails++;
      $display("[TB] FAIL go_frozen: got l=%0d r=%0d go=%0b, expected l=0 r=%0d go=1", lscore, rscore, game_over, WIN);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (lscore !== 4'd0 || rscore !== 4'd0 || game_over !== 1'b0 || ball_reset !== 1'b1) begin
      fails++;
      $display("[TB] FAIL go_restart: got l=%0d r=%0d go=%0b br=%0b, expected 0/0 go=0 br=1",
               lscore, rscore, game_over, ball_reset);
    end
    run_to_play(nb, npl, npr);
    checks++;
    if (nb != S) begin
      fails++;
      $display("[TB] FAIL go_reserve: got %0d, expected %0d", nb, S);
    end
  endtask

  task automatic test_random_match();
    int lexp, rexp, side, hold, nb, npl, npr, iter;
    bit done;
    lexp = 0; rexp = 0; done = 1'b0; iter = 0;
    while (!done && iter < 40) begin
      iter++;
      repeat ($urandom_range(0, 5)) step();
      if ($urandom_range(0, 9) == 0) begin
        out_left = 1'b1;
        out_right = 1'b1;
        step();
        out_left = 1'b0;
        out_right = 1'b0;
        step();
        checks++;
        if (lscore !== 4'(lexp) || rscore !== 4'(rexp) || ball_reset !== 1'b0) begin
          fails++;
          $display("[TB] FAIL rnd_both: got l=%0d r=%0d br=%0b, expected l=%0d r=%0d br=0",
                   lscore, rscore, ball_reset, lexp, rexp);
        end
      end else begin
        side = $urandom_range(0, 1);
        hold = $urandom_range(1, 3);
        if (side == 1) out_right = 1'b1;
        else out_left = 1'b1;
        step();
        if (side == 1) lexp++;
        else rexp++;
        checks++;
        if (lscore !== 4'(lexp) || rscore !== 4'(rexp)) begin
          fails++;
          $display("[TB] FAIL rnd_score: got l=%0d r=%0d, expected l=%0d r=%0d", lscore, rscore, lexp, rexp);
        end
        if (lexp == WIN || rexp == WIN) begin
          checks++;
          if (game_over !== 1'b1 || winner !== (rexp == WIN) || point_l !== 1'b0 || point_r !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rnd_over: got go=%0b w=%0b pl=%0b pr=%0b, expected go=1 w=%0b no point",
                     game_over, winner, point_l, point_r, rexp == WIN);
          end
          out_left = 1'b0;
          out_right = 1'b0;
          done = 1'b1;
        end else begin
          checks++;
          if (point_l !== (side == 1) || point_r !== (side == 0)) begin
            fails++;
            $display("[TB] FAIL rnd_point_flag: got pl=%0b pr=%0b, expected pl=%0b pr=%0b",
                     point_l, point_r, side == 1, side == 0);
          end
          repeat (hold - 1) step();
          out_left = 1'b0;
          out_right = 1'b0;
          run_to_play(nb, npl, npr);
          checks++;
          if (nb != H + S - hold + 1 || (side == 1 ? npl : npr) != H - hold + 1 || lscore !== 4'(lexp) || rscore !== 4'(rexp)) begin
            fails++;
            $display("[TB] FAIL rnd_recovery: got br=%0d pt=%0d l=%0d r=%0d, expected br=%0d pt=%0d l=%0d r=%0d",
                     nb, (side == 1 ? npl : npr), lscore, rscore, H + S - hold + 1, H - hold + 1, lexp, rexp);
          end
        end
      end
    end
    checks++;
    if (done !== 1'b1 || game_over !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rnd_finished: got done=%0b go=%0b, expected 1/1", done, game_over);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_start_held();
    test_serve();
    test_point_held();
    test_simultaneous();
    test_reset_mid_point();
    test_game_over();
    test_random_match();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match controller that sits directly downstream of the ball block. It consumes the ball's `out_left`/`out_right` edge events, keeps both players' scores, and sequences the match through idle, serve, play, point-hold and game-over. It drives the ball block's `reset` so the ball re-centres between rallies, and supplies the ball's 5-bit `entropy` for a random serve direction. It runs on the same 2000 Hz game clock as the ball.

## Interface
Parameters:
- `WIN_SCORE`, 9: points needed to win; legal range 1..15.
- `SERVE_TICKS`, 1000: cycles the ball is held at centre before play starts (0.5 s at 2000 Hz); minimum 1.
- `HOLD_TICKS`, 1000: cycles the point indication is held after a point; minimum 1.

Ports:
- `clk`  in  1  game clock.
- `reset`  in  1  synchronous, active-high.
- `out_left`  in  1  ball left the left edge; point to the right player.
- `out_right`  in  1  ball left the right edge; point to the left player.
- `start`  in  1  start button, level; already debounced upstream.
- `ball_reset`  out  1  holds the ball block in reset (centred, new theta).
- `entropy`  out  5  serve randomness to the ball block.
- `lscore`  out  4  left player score.
- `rscore`  out  4  right player score.
- `point_l`  out  1  left scored; high during POINT only.
- `point_r`  out  1  right scored; high during POINT only.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over`.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `ball_reset`=1;
  - `lscore`=`rscore`=0;
  - `point_l`=`point_r`=0;
  - `game_over`=0;
  - `winner`=0;
  - `entropy`=5'b00001;
  - counter 0;
  - edge-detect history registers 0.
- Entropy: 5-bit Fibonacci LFSR with polynomial x^5+x^3+1. It advances every cycle in every state, except while `reset` is high. It never reaches 0.
- Edge detection:
  - `start_rise` = `start` & !`start_q`.
  - `evt_l` = `out_left` & !`outl_q`.
  - `evt_r` = `out_right` & !`outr_q`.
  - History registers update every cycle regardless of state.
- FSM:
  - IDLE: `ball_reset`=1. On `start_rise` go to SERVE and load the counter.
  - SERVE: `ball_reset`=1. The counter decrements. When it reaches 1, go to PLAY.
  - PLAY: `ball_reset`=0.
    - `evt_l` alone: `rscore`+1.
    - `evt_r` alone: `lscore`+1.
    - Both in the same cycle: no point, stay in PLAY.
    - After a point: if the new score equals WIN_SCORE, go to OVER and set `winner`. Otherwise go to POINT, set `point_l`/`point_r` and load HOLD_TICKS.
  - POINT: `ball_reset`=1. The counter decrements. At 1, clear `point_*` and go to SERVE, loading SERVE_TICKS.
  - OVER: `ball_reset`=1, `game_over`=1. Scores are frozen. On `start_rise`: clear scores, `game_over`=0, go to SERVE.
- Edge events and `start` are ignored in every state not listed for them above.
- A held-high `out_*` scores exactly once.
- Scores never exceed WIN_SCORE and need no wrap handling.
- `reset` asserted in any state returns to IDLE with reset values on the next edge, overriding all pending events.

## Timing
- Event at input during cycle N (PLAY): score, `point_*` and `ball_reset`=1 are all visible after edge N+1.
- SERVE entered at edge E: `ball_reset` deasserts at edge E+SERVE_TICKS.
- POINT lasts exactly HOLD_TICKS cycles, then SERVE_TICKS cycles of SERVE.
- Point to next play: HOLD_TICKS+SERVE_TICKS cycles of `ball_reset`=1 after the scoring edge.
- `start_rise` in IDLE/OVER at cycle N: SERVE from edge N+1.
- Because of the one-cycle `start_q` latency, a `start` held from reset release triggers at the first cycle after reset.

## Test plan
- Reset then idle 50 cycles: `ball_reset`=1, scores 0/0, `entropy` sequence non-zero with period 31.
- `start` pulse, SERVE_TICKS=4: `ball_reset` falls exactly 4 cycles after entering SERVE.
- In PLAY, `out_right` high for 3 cycles: `lscore`=1 once, `point_l`=1 for HOLD_TICKS, then SERVE, then PLAY.
- `out_left` and `out_right` in the same cycle during PLAY: scores unchanged, state stays PLAY.
- WIN_SCORE=3, three `evt_l`: `rscore`=3, `game_over`=1, `winner`=1. A further `out_*` is ignored. `start` clears to 0/0 and enters SERVE.
- `reset` asserted mid-POINT with `lscore`=2: next cycle IDLE, scores 0, `point_l`=0, `ball_reset`=1.
